// File: rtl/rx_frame_pkg.sv
// Shared state encoding and default geometry for the serial receive sequencer.
package rx_frame_pkg;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rxState_t;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Receive-side link bundle: tick/line in from the synchronizer, strobes and char out to the buffer.
interface rx_frame_ctrl_if import rx_frame_pkg::*; #(
   parameter int DATA_BITS = DEF_DATA_BITS
);
   logic                 sample_tick;
   logic                 rx_in;
   logic                 sr_clk;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 framing_err;
   logic                 parity_err;
   logic                 busy;

   modport master (
      output sample_tick, rx_in,
      input  sr_clk, data_out, data_valid, framing_err, parity_err, busy
   );

   modport slave (
      input  sample_tick, rx_in,
      output sr_clk, data_out, data_valid, framing_err, parity_err, busy
   );
endinterface

// File: rtl/rx_sample_timer.sv
// Oversample counter: flags the start-bit half point or the data/stop mid-bit, only on ticks.
// Latency: midHit is combinational from the counter; no backpressure.
module rx_sample_timer import rx_frame_pkg::*; #(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic clear,
   input  logic halfMode,
   output logic midHit
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] sampCnt;
   logic          atLast;

   assign atLast = (sampCnt == (halfMode ? HALF_LAST : FULL_LAST));
   assign midHit = tick & atLast & ~clear;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sampCnt <= '0;
      end else if (tick) begin
         if (clear || atLast) sampCnt <= '0;
         else                 sampCnt <= sampCnt + 1'b1;
      end
   end
endmodule

// File: rtl/rx_frame_ctrl.sv
// Start-bit validation, mid-bit shift strobes, LSB-first assembly; RX_PARITY_EN adds even parity.
// Latency: strobes/char registered 1 clk after the deciding tick; no backpressure (line-driven).
module rx_frame_ctrl import rx_frame_pkg::*; #(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int DATA_BITS  = DEF_DATA_BITS
) (
   input logic            clk,
   input logic            rst,
   rx_frame_ctrl_if.slave bus
);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rxState_t             state, nextState;
   logic [BW-1:0]        bitCnt;
   logic [DATA_BITS-1:0] shiftReg, dataReg;
   logic                 midHit, timerClear, halfMode;
   logic                 shiftEn, bitClear, goodStop, badStop;
   logic                 srClkReg, validReg, frameErrReg;

   rx_sample_timer #(.OVERSAMPLE(OVERSAMPLE)) sampleTimer (
      .clk      (clk),
      .rst      (rst),
      .tick     (bus.sample_tick),
      .clear    (timerClear),
      .halfMode (halfMode),
      .midHit   (midHit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

`ifdef RX_PARITY_EN
   logic parSample;
`endif

   always_comb begin
      nextState  = state;
      timerClear = 1'b0;
      shiftEn    = 1'b0;
      bitClear   = 1'b0;
      goodStop   = 1'b0;
      badStop    = 1'b0;
      halfMode   = (state == START);
`ifdef RX_PARITY_EN
      parSample  = 1'b0;
`endif
      case (state)
         IDLE: begin
            timerClear = 1'b1;
            if (bus.sample_tick && !bus.rx_in) nextState = START;
         end
         START: begin
            if (midHit) begin
               // Line back high at the half point is a glitch, not a start bit.
               if (!bus.rx_in) begin
                  nextState = DATA;
                  bitClear  = 1'b1;
               end else begin
                  nextState = IDLE;
               end
            end
         end
         DATA: begin
            if (midHit) begin
               shiftEn = 1'b1;
`ifdef RX_PARITY_EN
               if (bitCnt == LAST_BIT) nextState = PARITY;
`else
               if (bitCnt == LAST_BIT) nextState = STOP;
`endif
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (midHit) begin
               parSample = 1'b1;
               nextState = STOP;
            end
         end
`endif
         STOP: begin
            if (midHit) begin
               if (bus.rx_in) begin
                  goodStop  = 1'b1;
                  nextState = IDLE;
               end else begin
                  badStop   = 1'b1;
                  nextState = BREAK;
               end
            end
         end
         BREAK: begin
            timerClear = 1'b1;
            if (bus.sample_tick && bus.rx_in) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitCnt      <= '0;
         shiftReg    <= '0;
         dataReg     <= '0;
         srClkReg    <= 1'b0;
         validReg    <= 1'b0;
         frameErrReg <= 1'b0;
      end else begin
         srClkReg    <= shiftEn;
         validReg    <= goodStop;
         frameErrReg <= badStop;
         if (bitClear)     bitCnt <= '0;
         else if (shiftEn) bitCnt <= bitCnt + 1'b1;
         if (shiftEn)  shiftReg <= DATA_BITS'({bus.rx_in, shiftReg} >> 1);
         if (goodStop) dataReg  <= shiftReg;
      end
   end

`ifdef RX_PARITY_EN
   logic parLatch, parErrReg;

   // Even parity: data ones plus the parity bit must total an even count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parLatch  <= 1'b0;
         parErrReg <= 1'b0;
      end else begin
         if (parSample) parLatch <= (^shiftReg) ^ bus.rx_in;
         parErrReg <= (goodStop | badStop) & parLatch;
      end
   end
   assign bus.parity_err = parErrReg;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.sr_clk      = srClkReg;
   assign bus.data_out    = dataReg;
   assign bus.data_valid  = validReg;
   assign bus.framing_err = frameErrReg;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomized frames against a bit-period model; a negedge monitor pops expected characters.
module tb_rx_frame_ctrl;
   localparam int OS = 16;
   localparam int DB = 8;

   typedef struct {
      bit         fe;
      logic [7:0] data;
      bit         perr;
      int         stopGap;
   } evt_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rx_frame_ctrl_if #(.DATA_BITS(DB)) bus ();
   rx_frame_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         checks = 0;
   int         errors = 0;
   evt_t       evq[$];
   int         tickPer = 1;
   int         phase = 0;
   logic [7:0] lastGood = 8'h00;
   int         srCnt = 0;
   int         lastSr = -1;
   int         cyc = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic clkStep(output bit wasTick);
      wasTick = bus.sample_tick;
      @(posedge clk);
      #1;
      phase = (phase + 1) % tickPer;
      bus.sample_tick = (phase == 0);
   endtask

   task automatic ticks(input int n);
      bit t;
      int c = 0;
      while (c < n) begin
         clkStep(t);
         if (t) c++;
      end
   endtask

   // Line-level frame: start, DB data bits LSB first, optional parity, stop.
   task automatic sendFrame(input logic [7:0] d, input bit stopOk, input bit parBad);
      evt_t e;
      bit   p;
      p      = (^d) ^ parBad;
      e.fe   = !stopOk;
      if (stopOk) lastGood = d;
      e.data = lastGood;
`ifdef RX_PARITY_EN
      e.perr    = parBad;
      e.stopGap = 2 * OS * tickPer;
`else
      e.perr    = 1'b0;
      e.stopGap = OS * tickPer;
`endif
      evq.push_back(e);
      bus.rx_in = 1'b0;
      ticks(OS);
      for (int i = 0; i < DB; i++) begin
         bus.rx_in = d[i];
         ticks(OS);
      end
`ifdef RX_PARITY_EN
      bus.rx_in = p;
      ticks(OS);
`else
      if (p) bus.rx_in = 1'b1;
`endif
      bus.rx_in = stopOk;
      ticks(OS);
      if (!stopOk) begin
         ticks($urandom_range(2, 10));
         check("break_busy", bus.busy, 1'b1);
         bus.rx_in = 1'b1;
         ticks(2);
         check("break_release", bus.busy, 1'b0);
      end
      ticks($urandom_range(0, 5));
   endtask

   initial begin : monitor
      evt_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            srCnt  = 0;
            lastSr = -1;
         end else begin
            if (bus.sr_clk) begin
               if (lastSr >= 0) check("sr_spacing", cyc - lastSr, OS * tickPer);
               srCnt++;
               lastSr = cyc;
            end
            if (bus.data_valid || bus.framing_err || bus.parity_err) begin
               if (evq.size() == 0) begin
                  check("unexpected_event", 1, 0);
               end else begin
                  e = evq.pop_front();
                  check("data_valid", bus.data_valid, !e.fe);
                  check("framing_err", bus.framing_err, e.fe);
                  check("parity_err", bus.parity_err, e.perr);
                  check("data_out", bus.data_out, e.data);
                  check("busy_at_event", bus.busy, e.fe);
                  check("sr_count", srCnt, DB);
                  check("stop_latency", cyc - lastSr, e.stopGap);
               end
               srCnt  = 0;
               lastSr = -1;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin : stimulus
      bus.sample_tick = 1'b0;
      bus.rx_in       = 1'b1;
      #12;
      check("rst_sr_clk", bus.sr_clk, 1'b0);
      check("rst_valid", bus.data_valid, 1'b0);
      check("rst_framing", bus.framing_err, 1'b0);
      check("rst_parity", bus.parity_err, 1'b0);
      check("rst_data", bus.data_out, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
      rst = 1'b1;
      ticks(4);

      sendFrame(8'h41, 1'b1, 1'b0);
      check("idle_after_stop", bus.busy, 1'b0);

      // Short low glitch: must be rejected at the half-bit check.
      bus.rx_in = 1'b0;
      ticks(4);
      bus.rx_in = 1'b1;
      ticks(OS);
      check("false_start_busy", bus.busy, 1'b0);
      check("false_start_sr", srCnt, 0);

      sendFrame(8'h5A, 1'b0, 1'b0);

      // Abort mid-character with reset.
      bus.rx_in = 1'b0;
      ticks(OS);
      for (int i = 0; i < 3; i++) begin
         bus.rx_in = i[0];
         ticks(OS);
      end
      check("pre_reset_busy", bus.busy, 1'b1);
      rst = 1'b0;
      #1;
      check("mid_rst_sr_clk", bus.sr_clk, 1'b0);
      check("mid_rst_data", bus.data_out, 8'h00);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_valid", bus.data_valid, 1'b0);
      bus.rx_in = 1'b1;
      lastGood  = 8'h00;
      ticks(2);
      rst = 1'b1;
      ticks(2);
      sendFrame(8'h33, 1'b1, 1'b0);

      tickPer = 3;
      sendFrame(8'hC3, 1'b1, 1'b0);

`ifdef RX_PARITY_EN
      tickPer = 1;
      sendFrame(8'h41, 1'b1, 1'b1);
      sendFrame(8'h41, 1'b1, 1'b0);
`endif

      for (int n = 0; n < 30; n++) begin
         tickPer = $urandom_range(1, 3);
         sendFrame(8'($urandom), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
      end

      ticks(4);
      check("drain", evq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
